// File: rtl/sc7_sched_pkg.sv
// Shared types and default sizes for the sc7 instance scheduler.
package sc7_sched_pkg;

    localparam int N_REQ_DEFAULT    = 5;
    localparam int MAX_HOLD_DEFAULT = 16;

    // GAP is a mandatory one-cycle bubble between two tenures.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

endpackage : sc7_sched_pkg

// File: rtl/sc7_rr_pick.sv
// Combinational round-robin picker: finds the first set req bit starting
// one position after last_id, wrapping from N_REQ-1 back to 0.
module sc7_rr_pick
    import sc7_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_id,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] pick_id
);

    localparam int ID_W = $clog2(N_REQ);

    // Scan from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid   = 1'b0;
        pick_id = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[ID_W'((int'(last_id) + k) % N_REQ)]) begin
                valid   = 1'b1;
                pick_id = ID_W'((int'(last_id) + k) % N_REQ);
            end
        end
    end

endmodule : sc7_rr_pick

// File: rtl/sc7_inst_scheduler.sv
// Round-robin grant scheduler for the sc7 child instances.
// One requester owns the grant per tenure; a tenure ends on done from the
// owner or when the owner drops its request, followed by one GAP cycle.
// Optional feature: define SC7_SCHED_TIMEOUT_EN to bound each tenure to
// MAX_HOLD grant cycles and raise a sticky timeout_err when it is exceeded.
module sc7_inst_scheduler
    import sc7_sched_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEFAULT,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy
`ifdef SC7_SCHED_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    localparam int ID_W = $clog2(N_REQ);

    // Reject configurations the arbiter cannot represent.
    if (N_REQ < 2) begin : g_bad_n_req
        $error("sc7_inst_scheduler: N_REQ must be at least 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("sc7_inst_scheduler: MAX_HOLD must be at least 1");
    end

    sched_state_t      state;
    logic [ID_W-1:0]   last_id;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic [N_REQ-1:0]  pick_onehot;
    logic              tenure_end;

`ifdef SC7_SCHED_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt;
`endif

    sc7_rr_pick #(
        .N_REQ   (N_REQ)
    ) u_rr_pick (
        .req     (req),
        .last_id (last_id),
        .valid   (pick_valid),
        .pick_id (pick_id)
    );

    assign pick_onehot = N_REQ'(1) << pick_id;

    // Owner releases the grant with done or by abandoning its request.
    assign tenure_end = done[gnt_id] | ~req[gnt_id];

    // Scheduler FSM with registered grant outputs, last_id and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            last_id <= ID_W'(N_REQ - 1);
`ifdef SC7_SCHED_TIMEOUT_EN
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            case (state)
                IDLE, GAP: begin
                    if (pick_valid) begin
                        state   <= GRANT;
                        gnt     <= pick_onehot;
                        gnt_id  <= pick_id;
                        busy    <= 1'b1;
                        last_id <= pick_id;
`ifdef SC7_SCHED_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end

                GRANT: begin
`ifdef SC7_SCHED_TIMEOUT_EN
                    hold_cnt <= hold_cnt + 1'b1;
`endif
                    if (tenure_end) begin
                        state <= GAP;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
`ifdef SC7_SCHED_TIMEOUT_EN
                    else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                        state       <= GAP;
                        gnt         <= '0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : sc7_inst_scheduler

// File: tb/tb_sc7_inst_scheduler.sv
// Self-checking bench for sc7_inst_scheduler: directed scenarios plus
// randomized traffic compared against a tenure-level reference model.
module tb_sc7_inst_scheduler;

    localparam int N        = 5;
    localparam int MAX_HOLD = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_id;
    logic         busy;
`ifdef SC7_SCHED_TIMEOUT_EN
    logic         timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the grant, who was granted last, tenure age.
    int m_owner;
    int m_last;
    int m_gid;
    int m_held;
    bit m_err;

    sc7_inst_scheduler #(
        .N_REQ    (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
`ifdef SC7_SCHED_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_ref(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_gid   = 0;
        m_held  = 0;
        m_err   = 1'b0;
    endtask

    // One clock edge of the scheduling rules, applied to the inputs seen at that edge.
    task automatic model_step(logic [N-1:0] r, logic [N-1:0] d);
        int p;
        if (m_owner >= 0) begin
            if (d[m_owner] || !r[m_owner]) begin
                m_owner = -1;
            end else begin
                m_held++;
`ifdef SC7_SCHED_TIMEOUT_EN
                if (m_held >= MAX_HOLD) begin
                    m_owner = -1;
                    m_err   = 1'b1;
                end
`endif
            end
        end else begin
            p = rr_ref(r, m_last);
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
                m_gid   = p;
                m_held  = 0;
            end
        end
    endtask

    // Drive inputs, take one edge, update the model, settle past the edge.
    task automatic cycle(logic [N-1:0] r, logic [N-1:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gnt !== '0 || gnt_id !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b gnt_id=%0d busy=%b, expected 00000/0/0", gnt, gnt_id, busy);
        end
`ifdef SC7_SCHED_TIMEOUT_EN
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
        end
`endif
        rst = 1'b0;
        model_reset();
        cycle('0, '0);
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: gnt=%b busy=%b, expected 00000/0", gnt, busy);
        end
    endtask

    task automatic test_single();
        apply_reset();
        cycle(5'b00100, '0);
        checks++;
        if (gnt !== 5'b00100 || gnt_id !== 3'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b gnt_id=%0d busy=%b, expected 00100/2/1", gnt, gnt_id, busy);
        end
        cycle(5'b00100, 5'b00100);
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_gap: gnt=%b busy=%b, expected 00000/0", gnt, busy);
        end
        cycle('0, '0);
        checks++;
        if (gnt !== '0 || busy !== 1'b0 || gnt_id !== 3'd2) begin
            errors++;
            $display("FAIL single_idle: gnt=%b busy=%b gnt_id=%0d, expected 00000/0/2", gnt, busy, gnt_id);
        end
    endtask

    task automatic test_round_robin();
        int order[6] = '{0, 1, 2, 3, 4, 0};
        apply_reset();
        cycle(5'b11111, '0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (gnt !== (N'(1) << order[i]) || gnt_id !== 3'(order[i])) begin
                errors++;
                $display("FAIL rr_order[%0d]: gnt=%b gnt_id=%0d, expected id %0d", i, gnt, gnt_id, order[i]);
            end
            if (i < 5) begin
                cycle(5'b11111, N'(1) << order[i]);
                checks++;
                if (gnt !== '0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_gap[%0d]: gnt=%b busy=%b, expected 00000/0", i, gnt, busy);
                end
                cycle(5'b11111, '0);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        cycle(5'b10000, '0);
        cycle('0, 5'b10000);
        cycle('0, '0);
        cycle(5'b10001, '0);
        checks++;
        if (gnt !== 5'b00001 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL wrap_to_zero: gnt=%b gnt_id=%0d, expected 00001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_stray_done();
        apply_reset();
        cycle(5'b00010, '0);
        cycle(5'b00010, 5'b01000);
        checks++;
        if (gnt !== 5'b00010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_done: gnt=%b busy=%b, expected 00010/1", gnt, busy);
        end
        cycle(5'b00010, 5'b11101);
        checks++;
        if (gnt !== 5'b00010) begin
            errors++;
            $display("FAIL stray_done_multi: gnt=%b expected 00010", gnt);
        end
        cycle('0, 5'b00010);
    endtask

    task automatic test_abandon();
        apply_reset();
        cycle(5'b01000, '0);
        cycle(5'b00001, '0);
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abandon_gap: gnt=%b busy=%b, expected 00000/0", gnt, busy);
        end
`ifdef SC7_SCHED_TIMEOUT_EN
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL abandon_no_err: timeout_err=%b expected 0", timeout_err);
        end
`endif
        cycle(5'b00001, '0);
        checks++;
        if (gnt !== 5'b00001 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL abandon_next: gnt=%b gnt_id=%0d, expected 00001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        cycle(5'b01000, '0);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== '0 || busy !== 1'b0 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b busy=%b gnt_id=%0d, expected 00000/0/0", gnt, busy, gnt_id);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(5'b11111, '0);
        checks++;
        if (gnt !== 5'b00001 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_grant: gnt=%b gnt_id=%0d, expected 00001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_hold_limit();
        apply_reset();
        cycle(5'b01000, '0);
`ifdef SC7_SCHED_TIMEOUT_EN
        for (int k = 1; k < MAX_HOLD; k++) begin
            cycle(5'b01000, '0);
            checks++;
            if (gnt !== 5'b01000) begin
                errors++;
                $display("FAIL timeout_hold[%0d]: gnt=%b expected 01000", k, gnt);
            end
        end
        cycle(5'b01000, '0);
        checks++;
        if (gnt !== '0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_revoke: gnt=%b err=%b, expected 00000/1", gnt, timeout_err);
        end
        cycle(5'b01000, '0);
        cycle('0, 5'b01000);
        cycle('0, '0);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b expected 1", timeout_err);
        end
        apply_reset();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: err=%b expected 0", timeout_err);
        end
`else
        for (int k = 1; k <= 3 * MAX_HOLD; k++) begin
            cycle(5'b01000, '0);
            checks++;
            if (gnt !== 5'b01000) begin
                errors++;
                $display("FAIL unbounded_hold[%0d]: gnt=%b expected 01000", k, gnt);
            end
        end
        cycle('0, 5'b01000);
`endif
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] d;
        apply_reset();
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            d = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            cycle(r, d);
            checks++;
            if (gnt !== exp_gnt() || gnt_id !== 3'(m_gid) || busy !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL random[%0d]: gnt=%b gnt_id=%0d busy=%b, expected %b/%0d/%b",
                         i, gnt, gnt_id, busy, exp_gnt(), m_gid, (m_owner >= 0));
            end
            checks++;
            if ($countones(gnt) > 1) begin
                errors++;
                $display("FAIL random_onehot[%0d]: gnt=%b expected at most one bit", i, gnt);
            end
`ifdef SC7_SCHED_TIMEOUT_EN
            checks++;
            if (timeout_err !== m_err) begin
                errors++;
                $display("FAIL random_err[%0d]: err=%b expected %b", i, timeout_err, m_err);
            end
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_stray_done();
        test_abandon();
        test_reset_mid_grant();
        test_hold_limit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sc7_inst_scheduler

// File: doc/sc7_inst_scheduler.md
SC7_INST_SCHEDULER -- requirements
Module: sc7_inst_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 5, the number of requesters (the five sc7 child instances).
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, the maximum number of grant cycles per tenure (used only with the timeout feature).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  N_REQ  per-requester request level, held high until served.
REQ-006 done  input  N_REQ  per-requester one-cycle release pulse; SHALL be honoured only from the granted index.
REQ-007 gnt  output  N_REQ  one-hot grant, or all-zero.
REQ-008 gnt_id  output  $clog2(N_REQ)  index of the current or last grant.
REQ-009 busy  output  1  high while in the GRANT state.
REQ-010 timeout_err  output  1  sticky error flag, present only when SC7_SCHED_TIMEOUT_EN is defined.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT, GAP.
REQ-012 IDLE -> GRANT SHALL occur on the first edge at which req != 0; gnt SHALL assert on that edge, giving 1-cycle latency from req to gnt.
REQ-013 Arbitration SHALL be round-robin: the search starts at index (last_id+1) mod N_REQ, wraps past N_REQ-1 to 0, and selects the first set req bit.
REQ-014 GRANT -> GAP SHALL occur when done[gnt_id] is high; gnt SHALL deassert on that edge.
REQ-015 GRANT -> GAP SHALL also occur when req[gnt_id] drops without done (requester abandon); no error is raised in this case.
REQ-016 GAP SHALL last exactly one cycle with gnt=0, then go to GRANT if any req is high, else to IDLE.
REQ-017 done bits from non-granted indices SHALL be ignored.
REQ-018 A simultaneous done[gnt_id] and new req from another index SHALL result in a grant to that index two edges later (via GAP).
REQ-019 gnt SHALL never have more than one bit set, and gnt SHALL be zero in IDLE and GAP.
REQ-020 last_id SHALL update only when a grant is issued.

Reset
REQ-021 On rst high, all state SHALL clear immediately: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout_err=0, last_id=N_REQ-1 (so index 0 has first priority).
REQ-022 If rst asserts during GRANT, the grant SHALL drop asynchronously, with no GAP cycle.
REQ-023 After rst deasserts, arbitration SHALL resume from the first rising edge.

Configuration
REQ-024 Macro SC7_SCHED_TIMEOUT_EN controls the hold-timeout feature.
REQ-025 With SC7_SCHED_TIMEOUT_EN defined:
- a hold counter SHALL clear on every grant and increment on each GRANT cycle;
- when the counter reaches MAX_HOLD without done, the grant SHALL be revoked (GRANT -> GAP) and timeout_err SHALL be set;
- timeout_err SHALL be cleared only by rst.
REQ-026 Without SC7_SCHED_TIMEOUT_EN, the counter and the timeout_err port SHALL be absent, and a tenure SHALL be unbounded.

Structure
REQ-027 Package sc7_sched_pkg SHALL hold the state enum (IDLE, GRANT, GAP) and the constants N_REQ_DEFAULT=5 and MAX_HOLD_DEFAULT=16.
REQ-028 The round-robin priority search SHALL be a combinational sub-module, sc7_rr_pick, with inputs req and last_id and outputs valid and pick_id.
REQ-029 The FSM, last_id register and hold counter SHALL reside in sc7_inst_scheduler.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Single request: after reset, req=5'b00100 -> gnt=5'b00100 and gnt_id=2 one edge later; done[2] pulse -> gnt=0 for one cycle, then IDLE.
- Round-robin order: req=5'b11111 held, done pulsed each tenure -> grant order 0,1,2,3,4,0 with one gap cycle between grants.
- Wrap-around: last_id=4, req=5'b10001 -> grant goes to 0, not 4.
- Stray done: grant held by 1, done=5'b01000 -> gnt remains 5'b00010.
- Reset mid-grant: rst asserted while gnt=5'b01000 -> gnt=0 with no clock edge; first grant after release goes to index 0 when req=5'b11111.
- Timeout (macro defined, MAX_HOLD=16): requester 3 holds the grant with no done -> gnt drops after 16 GRANT cycles, timeout_err=1 and stays 1 until rst.
